// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate L1 data cache.
// Owns tag/valid/dirty; drives the 32x256 data SRAM and the line memory port.
module dcache_controller #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 5,
  parameter int LINE_W  = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_write_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic [INDEX_W-1:0] sram_addr_o,
  output logic [LINE_W-1:0] sram_data_o,
  output logic              sram_enable_o,
  output logic              sram_write_o,
  input  logic [LINE_W-1:0] sram_data_i,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W;
  localparam int LINES  = 1 << INDEX_W;
  localparam int WORD_W = OFF_W - 2;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } state_e;

  state_e state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic             tag_we;

  logic [TAG_W-1:0]   cpu_tag;
  logic [INDEX_W-1:0] idx;
  logic [WORD_W-1:0]  word;
  logic               hit;
  logic [LINE_W-1:0]  merged;
  logic               unused_addr;

  assign cpu_tag     = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign idx         = cpu_addr_i[OFF_W +: INDEX_W];
  assign word        = cpu_addr_i[2 +: WORD_W];
  assign unused_addr = ^cpu_addr_i[1:0];
  assign hit = cpu_req_i & valid_q[idx]
             & (tag_q[idx] == cpu_tag);

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    tag_we        = 1'b0;
    cpu_data_o    = '0;
    cpu_stall_o   = 1'b0;
    sram_addr_o   = '0;
    sram_data_o   = '0;
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    mem_enable_o  = 1'b0;
    mem_write_o   = 1'b0;
    mem_addr_o    = '0;
    mem_data_o    = '0;
    merged        = sram_data_i;
    merged[32*word +: 32] = cpu_data_i;
    // Outputs are held quiet for as long as reset is asserted.
    if (rst_i) begin
      sram_addr_o = idx;
      unique case (state_q)
        IDLE: begin
          if (cpu_req_i) begin
            sram_enable_o = 1'b1;
            if (hit && cpu_write_i) begin
              sram_write_o = 1'b1;
              sram_data_o  = merged;
              dirty_d[idx] = 1'b1;
            end else if (hit) begin
              cpu_data_o = sram_data_i[32*word +: 32];
            end else begin
              cpu_stall_o = 1'b1;
              state_d = (valid_q[idx] & dirty_q[idx])
                      ? WRITEBACK : REFILL;
            end
          end
        end
        WRITEBACK: begin
          cpu_stall_o   = 1'b1;
          sram_enable_o = 1'b1;
          mem_enable_o  = 1'b1;
          mem_write_o   = 1'b1;
          mem_addr_o    = {tag_q[idx], idx, {OFF_W{1'b0}}};
          mem_data_o    = sram_data_i;
          if (mem_ack_i) state_d = REFILL;
        end
        REFILL: begin
          cpu_stall_o  = 1'b1;
          mem_enable_o = 1'b1;
          mem_addr_o   = {cpu_tag, idx, {OFF_W{1'b0}}};
          if (mem_ack_i) begin
            sram_enable_o = 1'b1;
            sram_write_o  = 1'b1;
            sram_data_o   = mem_data_i;
            tag_we        = 1'b1;
            valid_d[idx]  = 1'b1;
            dirty_d[idx]  = 1'b0;
            state_d       = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tags need no reset: a line is only trusted once valid is set.
  always_ff @(posedge clk_i) begin
    if (tag_we) tag_q[idx] <= cpu_tag;
  end

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: random and directed traffic against a flat-memory
// reference, with SRAM and line-memory models living in the bench.
module tb_dcache_controller;

  logic         clk;
  logic         rst_i;
  logic         cpu_req_i, cpu_write_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o;
  logic [4:0]   sram_addr_o;
  logic [255:0] sram_data_o, sram_data_i;
  logic         sram_enable_o, sram_write_o;
  logic         mem_enable_o, mem_write_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;

  int tests;
  int fails;

  dcache_controller dut (
    .clk_i(clk), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_addr_o(sram_addr_o), .sram_data_o(sram_data_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
    .sram_data_i(sram_data_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // data SRAM: combinational read, negedge write
  logic [255:0] sram [32];
  assign sram_data_i = sram_enable_o ? sram[sram_addr_o] : '0;
  always @(negedge clk)
    if (sram_enable_o && sram_write_o)
      sram[sram_addr_o] <= sram_data_o;

  // backing memory and golden flat word memory
  logic [255:0] tbmem [logic [31:0]];
  logic [31:0]  gold  [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1357_9BDF;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    if (tbmem.exists(la)) return tbmem[la];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la + 32'(4*w));
    return l;
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    logic [31:0] wa;
    wa = a & ~32'h3;
    return gold.exists(wa) ? gold[wa] : init_word(wa);
  endfunction

  function automatic logic [255:0] gold_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = gold_rd(la + 32'(4*w));
    return l;
  endfunction

  task automatic preset(input logic [31:0] a, input logic [31:0] v);
    logic [255:0] l;
    logic [31:0] la;
    la = a & ~32'h1F;
    l = mem_line(la);
    l[a[4:2]*32 +: 32] = v;
    tbmem[la] = l;
    gold[a & ~32'h3] = v;
  endtask

  // memory responder: random latency, one-cycle ack
  logic         resp_ack, spur_ack, resp_en, busy;
  logic [255:0] resp_data, spur_data;
  int           wait_left, cyc, wb_n, rf_n, wb_cnt;
  logic [31:0]  wb_addr, rf_addr;
  assign mem_ack_i  = resp_ack | spur_ack;
  assign mem_data_i = resp_ack ? resp_data : spur_data;

  initial begin
    resp_ack = 0; busy = 0; wb_cnt = 0; cyc = 0;
    wait_left = 0; wb_n = 0; rf_n = 0;
    resp_data = '0; wb_addr = '0; rf_addr = '0;
    forever begin
      @(posedge clk); #1;
      resp_ack = 0;
      if (!rst_i || !mem_enable_o) busy = 0;
      else begin
        if (!busy && resp_en) begin
          busy = 1; cyc = 0;
          wait_left = $urandom_range(0, 3);
        end
        if (busy) begin
          cyc++;
          if (wait_left == 0) begin
            resp_ack = 1; busy = 0;
            if (mem_write_o) begin
              tbmem[mem_addr_o] = mem_data_o;
              wb_n = cyc; wb_addr = mem_addr_o; wb_cnt++;
            end else begin
              resp_data = mem_line(mem_addr_o);
              rf_n = cyc; rf_addr = mem_addr_o;
            end
          end else wait_left--;
        end
      end
    end
  end

  // cache-state reference
  bit   [31:0] mvalid, mdirty;
  logic [21:0] mtag [32];

  // dirty data is lost on reset: golden view falls back to memory
  task automatic model_reset();
    logic [31:0] la;
    logic [255:0] l;
    for (int i = 0; i < 32; i++)
      if (mvalid[i] && mdirty[i]) begin
        la = {mtag[i], 5'(i), 5'b0};
        l = mem_line(la);
        for (int w = 0; w < 8; w++) gold[la + 32'(4*w)] = l[w*32 +: 32];
      end
    mvalid = '0;
    mdirty = '0;
  endtask

  task automatic do_access(input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, output int stalls,
                           output logic [31:0] rd, output bit saw_wr);
    int idx, wb0, exp_st;
    logic [21:0] tg;
    bit m_hit, m_wb, p_en, p_ack, p_wr;
    logic [31:0] exp_wba, p_addr;
    logic [255:0] p_data;
    idx = int'(a[9:5]);
    tg = a[31:10];
    m_hit = mvalid[idx] && mtag[idx] == tg;
    m_wb = !m_hit && mvalid[idx] && mdirty[idx];
    exp_wba = {mtag[idx], a[9:5], 5'b0};
    wb0 = wb_cnt;
    @(posedge clk); #1;
    cpu_req_i = 1; cpu_write_i = wr;
    cpu_addr_i = a; cpu_data_i = wd;
    #2;
    stalls = 0; saw_wr = 0; p_en = 0; p_ack = 0;
    p_wr = 0; p_addr = '0; p_data = '0;
    if (cpu_stall_o) begin
      tests++;
      if (cpu_data_o !== 32'h0) begin
        fails++;
        $display("FAIL stall_data: got %h want 0", cpu_data_o);
      end
    end
    while (cpu_stall_o && stalls < 40) begin
      if (mem_enable_o && mem_write_o) saw_wr = 1;
      if (p_en && !p_ack) begin
        tests++;
        if (!mem_enable_o || mem_addr_o !== p_addr ||
            mem_write_o !== p_wr || mem_data_o !== p_data) begin
          fails++;
          $display("FAIL mem_stable: en %b addr %h want 1 %h",
                   mem_enable_o, mem_addr_o, p_addr);
        end
      end
      p_en = mem_enable_o; p_ack = mem_ack_i; p_wr = mem_write_o;
      p_addr = mem_addr_o; p_data = mem_data_o;
      stalls++;
      @(posedge clk); #3;
    end
    rd = cpu_data_o;
    exp_st = m_hit ? 0 : 1 + (m_wb ? wb_n : 0) + rf_n;
    tests++;
    if (stalls !== exp_st) begin
      fails++;
      $display("FAIL stall_cycles @%h: got %0d want %0d", a, stalls, exp_st);
    end
    tests++;
    if ((wb_cnt - wb0) !== int'(m_wb)) begin
      fails++;
      $display("FAIL wb_count @%h: got %0d want %0d", a, wb_cnt - wb0, m_wb);
    end
    if (m_wb) begin
      tests++;
      if (wb_addr !== exp_wba || mem_line(exp_wba) !== gold_line(exp_wba)) begin
        fails++;
        $display("FAIL wb_line: addr %h want %h", wb_addr, exp_wba);
      end
    end
    if (!m_hit) begin
      tests++;
      if (rf_addr !== {tg, a[9:5], 5'b0}) begin
        fails++;
        $display("FAIL rf_addr: got %h want %h", rf_addr, {tg, a[9:5], 5'b0});
      end
    end
    tests++;
    if (wr) begin
      if (rd !== 32'h0) begin
        fails++;
        $display("FAIL store_data_o: got %h want 0", rd);
      end
      gold[a & ~32'h3] = wd;
    end else if (rd !== gold_rd(a)) begin
      fails++;
      $display("FAIL load @%h: got %h want %h", a, rd, gold_rd(a));
    end
    mvalid[idx] = 1;
    mtag[idx] = tg;
    if (!m_hit) mdirty[idx] = 0;
    if (wr) mdirty[idx] = 1;
  endtask

  task automatic test_reset();
    rst_i = 0; cpu_req_i = 0; cpu_write_i = 0;
    cpu_addr_i = 0; cpu_data_i = 0;
    spur_ack = 0; spur_data = '0; resp_en = 1;
    mvalid = '0; mdirty = '0;
    repeat (2) @(posedge clk); #3;
    tests++;
    if ({cpu_stall_o, mem_enable_o, sram_enable_o, sram_write_o,
         mem_write_o} !== 5'b0 || cpu_data_o !== 32'h0) begin
      fails++;
      $display("FAIL reset_outs: stall %b men %b sen %b swr %b",
               cpu_stall_o, mem_enable_o, sram_enable_o, sram_write_o);
    end
    rst_i = 1;
    @(posedge clk); #3;
    tests++;
    if ({cpu_stall_o, mem_enable_o, sram_enable_o} !== 3'b0) begin
      fails++;
      $display("FAIL idle_outs: stall %b men %b sen %b",
               cpu_stall_o, mem_enable_o, sram_enable_o);
    end
  endtask

  task automatic test_fill_load();
    int st;
    logic [31:0] rd;
    bit sw;
    preset(32'h48, 32'hDEAD_BEEF);
    do_access(0, 32'h40, 0, st, rd, sw);
    tests++;
    if (st < 2) begin
      fails++;
      $display("FAIL fill_stall: got %0d want >=2", st);
    end
    do_access(0, 32'h48, 0, st, rd, sw);
    tests++;
    if (rd !== 32'hDEAD_BEEF || st !== 0) begin
      fails++;
      $display("FAIL fill_word2: got %h/%0d want deadbeef/0", rd, st);
    end
  endtask

  task automatic test_store_hit();
    int st;
    logic [31:0] rd;
    bit sw;
    do_access(1, 32'h44, 32'h1234_5678, st, rd, sw);
    tests++;
    if (st !== 0 || !mdirty[2]) begin
      fails++;
      $display("FAIL store_hit: stall got %0d want 0", st);
    end
    do_access(0, 32'h44, 0, st, rd, sw);
    tests++;
    if (rd !== 32'h1234_5678) begin
      fails++;
      $display("FAIL store_readback: got %h want 12345678", rd);
    end
  endtask

  task automatic test_dirty_evict();
    int st;
    logic [31:0] rd;
    bit sw;
    do_access(0, 32'h444, 0, st, rd, sw);
    tests++;
    if (!sw || wb_addr !== 32'h40 || rf_addr !== 32'h440) begin
      fails++;
      $display("FAIL dirty_evict: wb %h rf %h want 40 440", wb_addr, rf_addr);
    end
  endtask

  task automatic test_clean_conflict();
    int st;
    logic [31:0] rd;
    bit sw;
    do_access(0, 32'h44, 0, st, rd, sw);
    tests++;
    if (sw || rd !== 32'h1234_5678) begin
      fails++;
      $display("FAIL clean_conflict: memwr %b data %h want 0 12345678", sw, rd);
    end
  endtask

  task automatic test_random_traffic();
    int st;
    logic [31:0] rd, a;
    bit sw;
    for (int n = 0; n < 200; n++) begin
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 5)
        | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      do_access(1'($urandom_range(0, 1)), a, $urandom, st, rd, sw);
    end
  endtask

  task automatic test_spurious_ack();
    int st;
    logic [31:0] rd;
    bit sw;
    @(posedge clk); #1;
    cpu_req_i = 0;
    spur_ack = 1;
    spur_data = {8{$urandom}};
    #2;
    tests++;
    if ({sram_enable_o, sram_write_o, mem_enable_o, cpu_stall_o} !== 4'b0) begin
      fails++;
      $display("FAIL spurious_ack: sen %b swr %b men %b stall %b",
               sram_enable_o, sram_write_o, mem_enable_o, cpu_stall_o);
    end
    @(posedge clk); #1;
    spur_ack = 0;
    spur_data = '0;
    for (int w = 0; w < 8; w++) do_access(0, 32'h40 + 32'(4*w), 0, st, rd, sw);
  endtask

  task automatic test_reset_mid_refill();
    int st;
    logic [31:0] rd;
    bit sw;
    resp_en = 0;
    @(posedge clk); #1;
    cpu_req_i = 1; cpu_write_i = 0; cpu_addr_i = 32'h3E0;
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0) begin
      fails++;
      $display("FAIL refill_pending: men %b mwr %b want 1 0", mem_enable_o, mem_write_o);
    end
    rst_i = 0;
    #1;
    tests++;
    if (mem_enable_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
      fails++;
      $display("FAIL async_abort: men %b stall %b want 0 0", mem_enable_o, cpu_stall_o);
    end
    model_reset();
    @(posedge clk); #1;
    cpu_req_i = 0;
    rst_i = 1;
    resp_en = 1;
    do_access(0, 32'h44, 0, st, rd, sw);
    tests++;
    if (st == 0) begin
      fails++;
      $display("FAIL post_reset_miss: stall got 0 want >0");
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 32; i++) sram[i] = {8{$urandom}};
    test_reset();
    test_fill_load();
    test_store_hit();
    test_dirty_evict();
    test_clean_conflict();
    test_random_traffic();
    test_spurious_ack();
    test_reset_mid_refill();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
